pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and stall controller for the 5-stage MIPS pipeline. It drives the hold and flush controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It sequences load-use stalls, taken-branch flushes, multi-cycle data-memory waits and the halt state, and it keeps performance counters.

## Interface
- MEM_LAT, 2: extra cycles a data-memory access stays in MEM (0 = single-cycle memory).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; synchronous and active-low.
- id_valid, id_uses_rs, id_uses_rt  input  1 each  ID instruction is effective and reads rs / rt.
- id_rs, id_rt  input  5 each  ID source register numbers.
- ex_valid, ex_memread  input  1 each  EX instruction is effective and is a load.
- ex_rt  input  5  EX load destination register.
- mem_acc  input  1  MEM stage holds an effective load or store.
- branch_taken  input  1  EX resolved a taken branch or jump (already valid-qualified).
- halt_req  input  1  WB holds an effective exit syscall.
- resume  input  1  single-cycle pulse that leaves HALT.
- pc_hold, ifid_hold, idex_hold, exmem_hold  output  1 each  Enable of each register; 1 = hold.
- ifid_flush, idex_flush, memwb_flush  output  1 each  bubble insert; meaningful only while the matching hold is 0.
- halted  output  1  state is HALT.
- cycle_cnt, stall_cnt, flush_cnt  output  CNT_W each  performance counters.

## Operation
- States: RUN, WAIT, HALT. A 2-bit state register and a down-counter `wcnt` (width clog2(MEM_LAT+1), minimum 1).
- Load-use hazard `lu` is asserted when all of these hold:
  - id_valid and ex_valid and ex_memread, and ex_rt != 0;
  - (id_uses_rs and ex_rt == id_rs) or (id_uses_rt and ex_rt == id_rt).
- Priority per cycle is reset > HALT > memory wait > branch > load-use.
- HALT: all holds are 1 and all flushes are 0.
  - resume → RUN.
  - halt_req is ignored in this state.
- Memory wait (`mw`) is asserted in two cases:
  - state RUN with mem_acc=1 and MEM_LAT>0;
  - state WAIT with wcnt != 0.
- While `mw` is asserted:
  - pc/ifid/idex/exmem holds are 1;
  - memwb_flush=1, so WB sees a bubble rather than re-writing.
  - branch_taken and `lu` are ignored; EX and ID are frozen and re-evaluate after the wait.
- Memory-wait transitions:
  - RUN with mw: wcnt <= MEM_LAT-1, go to WAIT.
  - WAIT with wcnt != 0: decrement wcnt.
  - WAIT with wcnt == 0: no hold, behave as RUN for branch/lu/halt; next state RUN.
- Branch (no mw): ifid_flush=1 and idex_flush=1, all holds 0. Any simultaneous `lu` is discarded because its instruction is squashed.
- Load-use (no mw, no branch): pc_hold=1, ifid_hold=1, idex_flush=1; all other holds 0.
- halt_req in RUN, or in WAIT with wcnt == 0: next state HALT. Controls in the current cycle follow the rules above.
- Counters, all wrapping modulo 2^CNT_W:
  - cycle_cnt: +1 every cycle the state is not HALT.
  - stall_cnt: +1 every cycle pc_hold=1 outside HALT.
  - flush_cnt: +1 per cycle a branch flush is emitted.

## Timing
- All hold/flush outputs are combinational from the current state and the inputs, with zero latency. They are sampled by the pipeline registers at the same edge.
- The state, wcnt and counters update on the rising edge of clk.
- While rst=0:
  - all holds are 0 and ifid_flush/idex_flush/memwb_flush are 1;
  - halted=0;
  - on the edge, state <= RUN, wcnt <= 0 and all counters <= 0.
- Reset asserted mid-WAIT or mid-HALT aborts that state at the next edge.
- A memory access first seen at edge t holds the pipeline for exactly MEM_LAT cycles. The instruction leaves MEM at the edge ending cycle t+MEM_LAT.
- A load-use stall lasts exactly 1 cycle: on the next cycle the load is in MEM and `lu` clears.
- A resume pulse arriving outside HALT is ignored.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, WAIT, HALT);
  - the REG_ZERO = 5'd0 constant;
  - the hold/flush bundle typedef shared with the pipeline-register instantiation in the top level.
- One sub-module, `hazard_detect`, computes `lu` combinationally from the ID/EX fields. The FSM, priority logic and counters live in `pipeline_ctrl`.

## Test plan
- Load-use: EX has `lw $8` (ex_rt=8), ID reads rs=8 → one cycle with pc_hold=1, ifid_hold=1, idex_flush=1; stall_cnt goes from 0 to 1. A repeat with ex_rt=0 gives no stall.
- Memory wait with MEM_LAT=2: mem_acc=1 at cycle 5 → pc/ifid/idex/exmem holds and memwb_flush are 1 in cycles 5–6 and all clear in cycle 7; stall_cnt=2.
- Branch and load-use together: branch_taken=1 and `lu`=1 in the same cycle → ifid_flush=1, idex_flush=1, pc_hold=0; flush_cnt=1.
- Branch during wait: branch_taken=1 during WAIT → no flush until the wait ends; then exactly one flush cycle is emitted.
- Halt: halt_req → halted=1 on the next cycle with all holds 1; cycle_cnt stays frozen for 10 cycles; a resume pulse returns to RUN and cycle_cnt resumes counting.
- Reset mid-WAIT with MEM_LAT=3: rst=0 at the second wait cycle → flushes asserted, holds 0, and on the next edge state=RUN with all counters 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//
// Shared types for the pipeline hazard/stall controller:
//   state_e     - controller state (RUN, WAIT, HALT)
//   REG_ZERO    - register $0, which never carries a real dependency
//   pipe_ctl_t  - hold/flush bundle driven to the PC and pipeline registers
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Hold = register keeps its value; flush = register loads a bubble.
    // A flush only has an effect while the matching hold is 0.
    typedef struct packed {
        logic pc_hold;
        logic ifid_hold;
        logic idex_hold;
        logic exmem_hold;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
    } pipe_ctl_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
//
// Combinational load-use detector. Flags the case where the instruction in
// ID reads a register that a load currently in EX has not yet produced.
//
// Ports:
//   id_valid, id_uses_rs, id_uses_rt  in   ID instruction effective / reads rs / rt
//   id_rs, id_rt                      in   ID source register numbers
//   ex_valid, ex_memread              in   EX instruction effective / is a load
//   ex_rt                             in   EX load destination register
//   lu                                out  load-use hazard
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    logic load_in_ex;
    logic rs_hit;
    logic rt_hit;

    // A load targeting $0 produces nothing anyone can depend on.
    assign load_in_ex = ex_valid && ex_memread && (ex_rt != REG_ZERO);
    assign rs_hit     = id_uses_rs && (ex_rt == id_rs);
    assign rt_hit     = id_uses_rt && (ex_rt == id_rt);
    assign lu         = id_valid && load_in_ex && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Central hazard and stall controller for the 5-stage MIPS pipeline.
// Sequences load-use stalls, taken-branch flushes, multi-cycle data-memory
// waits and the halt state, and keeps performance counters.
//
// Parameters:
//   MEM_LAT  extra cycles a data-memory access stays in MEM (0 = single cycle)
//   CNT_W    performance counter width
//
// Ports:
//   clk, rst                          in   clock; synchronous active-low reset
//   id_valid/id_uses_rs/id_uses_rt    in   ID instruction qualifiers
//   id_rs, id_rt                      in   ID source registers
//   ex_valid, ex_memread, ex_rt       in   EX load information
//   mem_acc                           in   MEM holds an effective load/store
//   branch_taken                      in   EX resolved a taken branch/jump
//   halt_req                          in   WB holds an effective exit syscall
//   resume                            in   pulse leaving HALT
//   pc_hold .. exmem_hold             out  register holds (1 = hold)
//   ifid_flush, idex_flush,
//   memwb_flush                       out  bubble inserts
//   halted                            out  controller is in HALT
//   cycle_cnt, stall_cnt, flush_cnt   out  performance counters (wrapping)
//   state_dbg                         out  current controller state
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_valid,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             mem_acc,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_dbg
);

    localparam int WCNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam bit HAS_WAIT = (MEM_LAT > 0);
    // Entering WAIT already accounts for the first held cycle.
    localparam logic [WCNT_W-1:0] WCNT_LOAD = HAS_WAIT ? WCNT_W'(MEM_LAT - 1) : '0;

    state_e            state;
    state_e            state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    pipe_ctl_t         ctl;
    logic              lu;
    logic              mw;
    logic              br_flush;

    hazard_detect u_hazard_detect (
        .id_valid   (id_valid),
        .id_uses_rs (id_uses_rs),
        .id_uses_rt (id_uses_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_valid   (ex_valid),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .lu         (lu)
    );

    // Next-state and control outputs. Priority: reset > HALT > memory wait
    // > branch > load-use.
    always_comb begin
        ctl       = '0;
        state_nxt = state;
        wcnt_nxt  = wcnt;
        mw        = 1'b0;
        br_flush  = 1'b0;

        if (!rst) begin
            // Reset drains every stage with bubbles; registers are cleared in
            // the sequential block.
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            ctl.memwb_flush = 1'b1;
        end else begin
            case (state)
                HALT: begin
                    ctl.pc_hold    = 1'b1;
                    ctl.ifid_hold  = 1'b1;
                    ctl.idex_hold  = 1'b1;
                    ctl.exmem_hold = 1'b1;
                    if (resume) begin
                        state_nxt = RUN;
                    end
                end
                RUN, WAIT: begin
                    mw = ((state == RUN) && mem_acc && HAS_WAIT) ||
                         ((state == WAIT) && (wcnt != '0));

                    if (mw) begin
                        // Freeze everything up to MEM; WB gets a bubble so the
                        // last retired instruction is not written twice.
                        ctl.pc_hold     = 1'b1;
                        ctl.ifid_hold   = 1'b1;
                        ctl.idex_hold   = 1'b1;
                        ctl.exmem_hold  = 1'b1;
                        ctl.memwb_flush = 1'b1;
                    end else if (branch_taken) begin
                        // Squashes the ID instruction, so any load-use on it
                        // is moot.
                        ctl.ifid_flush = 1'b1;
                        ctl.idex_flush = 1'b1;
                        br_flush       = 1'b1;
                    end else if (lu) begin
                        ctl.pc_hold    = 1'b1;
                        ctl.ifid_hold  = 1'b1;
                        ctl.idex_flush = 1'b1;
                    end

                    if (state == RUN) begin
                        if (halt_req) begin
                            state_nxt = HALT;
                        end else if (mw) begin
                            state_nxt = WAIT;
                            wcnt_nxt  = WCNT_LOAD;
                        end
                    end else begin
                        if (mw) begin
                            wcnt_nxt = wcnt - WCNT_W'(1);
                        end else if (halt_req) begin
                            state_nxt = HALT;
                        end else begin
                            state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            wcnt      <= '0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (ctl.pc_hold && (state != HALT)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign pc_hold     = ctl.pc_hold;
    assign ifid_hold   = ctl.ifid_hold;
    assign idex_hold   = ctl.idex_hold;
    assign exmem_hold  = ctl.exmem_hold;
    assign ifid_flush  = ctl.ifid_flush;
    assign idex_flush  = ctl.idex_flush;
    assign memwb_flush = ctl.memwb_flush;
    assign halted      = rst && (state == HALT);
    assign state_dbg   = state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl. Two instances share the stimulus:
// dut (MEM_LAT=2) and dut3 (MEM_LAT=3). Control outputs are packed as
// {pc, ifid, idex, exmem holds, ifid, idex, memwb flushes}.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;
    import pipe_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_uses_rs, id_uses_rt;
    logic [4:0] id_rs, id_rt;
    logic       ex_valid, ex_memread;
    logic [4:0] ex_rt;
    logic       mem_acc, branch_taken, halt_req, resume;

    logic        pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic        ifid_flush, idex_flush, memwb_flush, halted;
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
    logic [1:0]  state_dbg;

    logic        pc_hold3, ifid_hold3, idex_hold3, exmem_hold3;
    logic        ifid_flush3, idex_flush3, memwb_flush3, halted3;
    logic [31:0] cycle_cnt3, stall_cnt3, flush_cnt3;
    logic [1:0]  state_dbg3;

    logic [6:0] ctl, ctl3;
    assign ctl  = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_flush};
    assign ctl3 = {pc_hold3, ifid_hold3, idex_hold3, exmem_hold3, ifid_flush3, idex_flush3, memwb_flush3};

    localparam logic [6:0] C_IDLE  = 7'b0000_000;
    localparam logic [6:0] C_RST   = 7'b0000_111;
    localparam logic [6:0] C_LU    = 7'b1100_010;
    localparam logic [6:0] C_MW    = 7'b1111_001;
    localparam logic [6:0] C_BR    = 7'b0000_110;
    localparam logic [6:0] C_HALT  = 7'b1111_000;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.MEM_LAT(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_acc(mem_acc), .branch_taken(branch_taken),
        .halt_req(halt_req), .resume(resume),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
        .halted(halted), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state_dbg(state_dbg)
    );

    pipeline_ctrl #(.MEM_LAT(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_rs(id_rs), .id_rt(id_rt),
        .ex_valid(ex_valid), .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_acc(mem_acc), .branch_taken(branch_taken),
        .halt_req(halt_req), .resume(resume),
        .pc_hold(pc_hold3), .ifid_hold(ifid_hold3), .idex_hold(idex_hold3), .exmem_hold(exmem_hold3),
        .ifid_flush(ifid_flush3), .idex_flush(idex_flush3), .memwb_flush(memwb_flush3),
        .halted(halted3), .cycle_cnt(cycle_cnt3), .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3),
        .state_dbg(state_dbg3)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_rs = 0; id_rt = 0;
        ex_valid = 0; ex_memread = 0; ex_rt = 0;
        mem_acc = 0; branch_taken = 0; halt_req = 0; resume = 0;
    endtask

    task automatic apply_reset();
        rst = 0;
        clear_inputs();
        step();
        rst = 1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 0;
        clear_inputs();
        mem_acc = 1; branch_taken = 1; halt_req = 1;
        #1;
        checks++; if (ctl !== C_RST) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_RST); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
        step();
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, RUN); end
        checks++; if (cycle_cnt !== 32'd0 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", cycle_cnt, stall_cnt, flush_cnt);
        end
        rst = 1;
        clear_inputs();
    endtask

    task automatic test_load_use();
        apply_reset();
        id_valid = 1; id_uses_rs = 1; id_rs = 5'd8;
        ex_valid = 1; ex_memread = 1; ex_rt = 5'd8;
        #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_LU); end
        step();
        checks++; if (stall_cnt !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
        // load has moved on to MEM, EX now holds a bubble
        ex_valid = 0; ex_memread = 0;
        #1;
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_clear_ctl got=%b exp=%b", ctl, C_IDLE); end
        step();
        // load to $0 never stalls
        ex_valid = 1; ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
        #1;
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_zero_ctl got=%b exp=%b", ctl, C_IDLE); end
        step();
        // match through rt only
        ex_rt = 5'd13; id_rs = 5'd13; id_rt = 5'd13; id_uses_rs = 0; id_uses_rt = 1;
        #1;
        checks++; if (ctl !== C_LU) begin errors++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, C_LU); end
        step();
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=2", stall_cnt); end
        checks++; if (cycle_cnt !== 32'd4) begin errors++; $display("FAIL lu_cycle_cnt got=%0d exp=4", cycle_cnt); end
        // neither source used
        id_uses_rt = 0;
        #1;
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL lu_unused_ctl got=%b exp=%b", ctl, C_IDLE); end
        step();
        clear_inputs();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        step();
        step();
        mem_acc = 1;
        #1;
        checks++; if (ctl !== C_MW) begin errors++; $display("FAIL mw_c0_ctl got=%b exp=%b", ctl, C_MW); end
        step();
        checks++; if (state_dbg !== WAIT) begin errors++; $display("FAIL mw_state got=%0d exp=%0d", state_dbg, WAIT); end
        checks++; if (ctl !== C_MW) begin errors++; $display("FAIL mw_c1_ctl got=%b exp=%b", ctl, C_MW); end
        step();
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL mw_release_ctl got=%b exp=%b", ctl, C_IDLE); end
        step();
        mem_acc = 0;
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL mw_back_run got=%0d exp=%0d", state_dbg, RUN); end
        checks++; if (stall_cnt !== 32'd2) begin errors++; $display("FAIL mw_stall_cnt got=%0d exp=2", stall_cnt); end
        checks++; if (cycle_cnt !== 32'd5) begin errors++; $display("FAIL mw_cycle_cnt got=%0d exp=5", cycle_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch_lu();
        apply_reset();
        id_valid = 1; id_uses_rs = 1; id_rs = 5'd8;
        ex_valid = 1; ex_memread = 1; ex_rt = 5'd8;
        branch_taken = 1;
        #1;
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL br_lu_ctl got=%b exp=%b", ctl, C_BR); end
        step();
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL br_lu_flush_cnt got=%0d exp=1", flush_cnt); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL br_lu_stall_cnt got=%0d exp=0", stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_branch_wait();
        apply_reset();
        mem_acc = 1; branch_taken = 1;
        #1;
        checks++; if (ctl !== C_MW) begin errors++; $display("FAIL bw_c0_ctl got=%b exp=%b", ctl, C_MW); end
        step();
        checks++; if (ctl !== C_MW) begin errors++; $display("FAIL bw_c1_ctl got=%b exp=%b", ctl, C_MW); end
        step();
        checks++; if (ctl !== C_BR) begin errors++; $display("FAIL bw_release_ctl got=%b exp=%b", ctl, C_BR); end
        step();
        mem_acc = 0; branch_taken = 0;
        #1;
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL bw_after_ctl got=%b exp=%b", ctl, C_IDLE); end
        checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL bw_flush_cnt got=%0d exp=1", flush_cnt); end
        step();
        clear_inputs();
    endtask

    task automatic test_halt();
        apply_reset();
        resume = 1;
        step();
        resume = 0;
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL resume_ignored got=%0d exp=%0d", state_dbg, RUN); end
        halt_req = 1;
        #1;
        checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL halt_req_ctl got=%b exp=%b", ctl, C_IDLE); end
        step();
        halt_req = 0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got=%b exp=1", halted); end
        checks++; if (ctl !== C_HALT) begin errors++; $display("FAIL halt_ctl got=%b exp=%b", ctl, C_HALT); end
        for (int i = 0; i < 10; i++) begin
            halt_req = i[0];
            mem_acc  = i[1];
            step();
        end
        halt_req = 0; mem_acc = 0;
        checks++; if (cycle_cnt !== 32'd2) begin errors++; $display("FAIL halt_frozen got=%0d exp=2", cycle_cnt); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL halt_stall_cnt got=%0d exp=0", stall_cnt); end
        resume = 1;
        step();
        resume = 0;
        checks++; if (halted !== 1'b0 || state_dbg !== RUN) begin
            errors++; $display("FAIL halt_resume got=%b/%0d exp=0/%0d", halted, state_dbg, RUN);
        end
        checks++; if (cycle_cnt !== 32'd2) begin errors++; $display("FAIL halt_resume_cnt got=%0d exp=2", cycle_cnt); end
        step();
        checks++; if (cycle_cnt !== 32'd3) begin errors++; $display("FAIL halt_counting got=%0d exp=3", cycle_cnt); end
        // reset while halted
        halt_req = 1;
        step();
        halt_req = 0;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_again got=%b exp=1", halted); end
        rst = 0;
        #1;
        checks++; if (halted !== 1'b0 || ctl !== C_RST) begin
            errors++; $display("FAIL halt_rst got=%b/%b exp=0/%b", halted, ctl, C_RST);
        end
        step();
        rst = 1;
        checks++; if (state_dbg !== RUN) begin errors++; $display("FAIL halt_rst_state got=%0d exp=%0d", state_dbg, RUN); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        mem_acc = 1;
        #1;
        checks++; if (ctl3 !== C_MW) begin errors++; $display("FAIL rmw_c0_ctl got=%b exp=%b", ctl3, C_MW); end
        step();
        checks++; if (state_dbg3 !== WAIT) begin errors++; $display("FAIL rmw_wait got=%0d exp=%0d", state_dbg3, WAIT); end
        rst = 0;
        #1;
        checks++; if (ctl3 !== C_RST) begin errors++; $display("FAIL rmw_rst_ctl got=%b exp=%b", ctl3, C_RST); end
        step();
        checks++; if (state_dbg3 !== RUN) begin errors++; $display("FAIL rmw_state got=%0d exp=%0d", state_dbg3, RUN); end
        checks++; if (cycle_cnt3 !== 32'd0 || stall_cnt3 !== 32'd0 || flush_cnt3 !== 32'd0) begin
            errors++; $display("FAIL rmw_cnts got=%0d/%0d/%0d exp=0/0/0", cycle_cnt3, stall_cnt3, flush_cnt3);
        end
        rst = 1;
        mem_acc = 0;
        #1;
        checks++; if (ctl3 !== C_IDLE) begin errors++; $display("FAIL rmw_idle_ctl got=%b exp=%b", ctl3, C_IDLE); end
        step();
        // full three-cycle wait
        mem_acc = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl3 !== C_MW) begin errors++; $display("FAIL lat3_hold%0d got=%b exp=%b", i, ctl3, C_MW); end
            step();
        end
        checks++; if (ctl3 !== C_IDLE) begin errors++; $display("FAIL lat3_release got=%b exp=%b", ctl3, C_IDLE); end
        step();
        mem_acc = 0;
        checks++; if (stall_cnt3 !== 32'd3) begin errors++; $display("FAIL lat3_stall_cnt got=%0d exp=3", stall_cnt3); end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 0;
        clear_inputs();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_lu();
        test_branch_wait();
        test_halt();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
